// File: rtl/spi_alu_slave_if.sv
// SPI-style slave link: active-low select, one data bit each way per clock.
interface IF_SPI;
   logic nss;
   logic mosi;
   logic miso;

   modport SLAVE (
      input  nss,
      input  mosi,
      output miso
   );

   modport MASTER (
      output nss,
      output mosi,
      input  miso
   );
endinterface

// File: rtl/spi_alu_slave.sv
// Serial ALU slave: receives {op, A, B} MSB first, computes, and shifts the
// result back out on the next select window.
module spi_alu_slave #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   IF_SPI.SLAVE              spi,
   output logic              busy,
   output logic              frame_err,
   output logic [DATA_W-1:0] result_q
);

   localparam int F  = 2 + 2 * DATA_W;
   localparam int CW = $clog2(F + 2);
   localparam int SW = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      CALC,
      READY,
      SEND
   } state_t;

   state_t            state_q;
   logic [F-1:0]      frame_q;
   logic [CW-1:0]     cnt_q;
   logic [SW-1:0]     sent_q;
   logic [DATA_W-1:0] shift_q;
   logic              miso_q;
   logic              busy_q;
   logic              err_q;

   logic [1:0]        op;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] alu_d;

   assign op  = frame_q[F-1:F-2];
   assign opa = frame_q[F-3 -: DATA_W];
   assign opb = frame_q[DATA_W-1:0];

   always_comb begin
      alu_d = '0;
      case (op)
         2'b00:   alu_d = opa + opb;
         2'b01:   alu_d = opa - opb;
         2'b10:   alu_d = opa & opb;
         default: alu_d = opa ^ opb;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         frame_q  <= '0;
         cnt_q    <= '0;
         sent_q   <= '0;
         shift_q  <= '0;
         result_q <= '0;
         miso_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               miso_q <= 1'b0;
               if (!spi.nss) begin
                  frame_q <= {{(F-1){1'b0}}, spi.mosi};
                  cnt_q   <= CW'(1);
                  state_q <= RECV;
                  busy_q  <= 1'b1;
               end
            end
            RECV: begin
               if (!spi.nss) begin
                  frame_q <= {frame_q[F-2:0], spi.mosi};
                  if (cnt_q != CW'(F + 1))
                     cnt_q <= cnt_q + 1'b1;
               end else if (cnt_q == CW'(F)) begin
                  state_q <= CALC;
               end else begin
                  err_q   <= 1'b1;
                  frame_q <= '0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            CALC: begin
               result_q <= alu_d;
               shift_q  <= alu_d;
               miso_q   <= alu_d[DATA_W-1];
               cnt_q    <= '0;
               state_q  <= READY;
            end
            READY: begin
               if (!spi.nss) begin
                  shift_q <= shift_q << 1;
                  miso_q  <= shift_q[DATA_W-2];
                  sent_q  <= SW'(1);
                  state_q <= SEND;
               end
            end
            SEND: begin
               // shift_q[DATA_W-1] always mirrors the bit currently on miso
               if (!spi.nss && sent_q != SW'(DATA_W - 1)) begin
                  shift_q <= shift_q << 1;
                  miso_q  <= shift_q[DATA_W-2];
                  sent_q  <= sent_q + 1'b1;
               end else begin
                  err_q   <= spi.nss;
                  miso_q  <= 1'b0;
                  sent_q  <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               miso_q  <= 1'b0;
            end
         endcase
      end
   end

   assign spi.miso  = miso_q;
   assign busy      = busy_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_spi_alu_slave.sv
// Directed and random frames against a plain-arithmetic ALU model.
module tb_spi_alu_slave;

   localparam int W = 32;
   localparam int F = 2 + 2 * W;

   logic         clk = 1'b0;
   logic         rst;
   logic         busy;
   logic         ferr;
   logic [W-1:0] res;
   int           n_chk = 0;
   int           n_fail = 0;
   logic [W-1:0] exp_res = '0;

   IF_SPI spi_if ();

   spi_alu_slave #(.DATA_W(W)) dut (
      .clock     (clk),
      .reset     (rst),
      .spi       (spi_if),
      .busy      (busy),
      .frame_err (ferr),
      .result_q  (res)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs,
                        input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [1:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint unsigned m;
      m = 64'd1 << W;
      case (op)
         2'b00:   return W'((longint'(a) + longint'(b)) % m);
         2'b01:   return W'((longint'(a) + m - longint'(b)) % m);
         2'b10:   return a & b;
         default: return a ^ b;
      endcase
   endfunction

   // Shifts nbits of {op,a,b} MSB first (extra bits past F are zeros),
   // then raises nss for one edge.
   task automatic send_frame(input logic [1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int nbits);
      logic [F-1:0] fr;
      fr = {op, a, b};
      for (int i = 0; i < nbits; i++) begin
         spi_if.nss  = 1'b0;
         spi_if.mosi = (i < F) ? fr[F-1-i] : 1'b0;
         tick();
      end
      spi_if.nss  = 1'b1;
      spi_if.mosi = 1'b0;
      tick();
   endtask

   task automatic good_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] got;
      send_frame(op, a, b, F);
      check({tag, "_busy_calc"}, W'(busy), W'(1));
      tick();
      exp_res = model(op, a, b);
      check({tag, "_result_q"}, res, exp_res);
      check({tag, "_ready_msb"}, W'(spi_if.miso), W'(exp_res[W-1]));
      tick();
      got = '0;
      for (int k = 0; k < W; k++) begin
         spi_if.nss = 1'b0;
         got = {got[W-2:0], spi_if.miso};
         tick();
      end
      spi_if.nss = 1'b1;
      check({tag, "_readback"}, got, exp_res);
      check({tag, "_idle_busy"}, W'(busy), W'(0));
      check({tag, "_idle_miso"}, W'(spi_if.miso), W'(0));
      tick();
   endtask

   task automatic bad_end(input string tag);
      check({tag, "_err"}, W'(ferr), W'(1));
      check({tag, "_busy"}, W'(busy), W'(0));
      tick();
      check({tag, "_err_clr"}, W'(ferr), W'(0));
      check({tag, "_res_keep"}, res, exp_res);
   endtask

   initial begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rst         = 1'b1;
      spi_if.nss  = 1'b1;
      spi_if.mosi = 1'b0;
      tick();
      tick();
      check("rst_busy", W'(busy), W'(0));
      check("rst_err", W'(ferr), W'(0));
      check("rst_miso", W'(spi_if.miso), W'(0));
      check("rst_res", res, '0);
      rst = 1'b0;
      tick();

      good_op("add", 2'b00, 32'h5, 32'h7);
      good_op("sub", 2'b01, 32'h3, 32'h5);
      good_op("addwrap", 2'b00, 32'hFFFFFFFF, 32'h1);
      good_op("and", 2'b10, 32'hF0F0F0F0, 32'hFF00FF00);
      good_op("xor", 2'b11, 32'hF0F0F0F0, 32'hFF00FF00);

      send_frame(2'b00, 32'h1, 32'h1, 40);
      bad_end("short");
      good_op("after_short", 2'b01, 32'h100, 32'h1);

      send_frame(2'b00, 32'h7, 32'h7, F);
      tick();
      exp_res = model(2'b00, 32'h7, 32'h7);
      tick();
      for (int k = 0; k < 10; k++) begin
         spi_if.nss = 1'b0;
         tick();
      end
      spi_if.nss = 1'b1;
      tick();
      bad_end("abort_read");

      send_frame(2'b11, 32'hAAAA, 32'h5555, F + 1);
      bad_end("long");

      for (int i = 0; i < 30; i++) begin
         spi_if.nss  = 1'b0;
         spi_if.mosi = 1'($urandom);
         tick();
      end
      rst = 1'b1;
      tick();
      exp_res = '0;
      check("midrst_busy", W'(busy), W'(0));
      check("midrst_miso", W'(spi_if.miso), W'(0));
      check("midrst_err", W'(ferr), W'(0));
      check("midrst_res", res, '0);
      spi_if.nss = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      good_op("after_rst", 2'b00, 32'h12345678, 32'h11111111);

      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom);
         ra  = $urandom;
         rb  = $urandom;
         good_op($sformatf("rnd%0d", i), rop, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $fatal(1, "FAIL timeout: simulation did not finish");
   end

endmodule

// File: doc/spi_alu_slave.md
SPI_ALU_SLAVE -- requirements
Module: spi_alu_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width in bits; frame length F = 2 + 2*DATA_W (66 at default).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port spi, interface IF_SPI.SLAVE: nss input (active-low select), mosi input (1 bit per clock), miso output (1 bit).
REQ-005 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-006 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a malformed or aborted transfer.
REQ-007 SHALL have port result_q, output, DATA_W bits: last computed result, for debug.

Function
REQ-008 SHALL implement states IDLE, RECV, CALC, READY and SEND.
REQ-009 IDLE: miso=0; the first edge with nss=0 SHALL sample mosi as frame bit F-1, clear the bit counter to 1, and go to RECV.
REQ-010 RECV: each edge with nss=0 SHALL shift mosi into the frame register, MSB first, and increment the counter, saturating at F+1.
REQ-011 RECV, edge with nss=1 and counter==F: SHALL go to CALC.
REQ-012 RECV, edge with nss=1 and counter!=F (short or long frame): SHALL pulse frame_err, discard the frame, leave result_q unchanged, and go to IDLE.
REQ-013 Frame layout: bits [F-1:F-2] opcode, next DATA_W bits operand A, lowest DATA_W bits operand B.
REQ-014 Opcodes: 00 A+B, 01 A-B, 10 A AND B, 11 A XOR B; arithmetic SHALL wrap modulo 2^DATA_W, with no carry or borrow output.
REQ-015 CALC SHALL last exactly one cycle: load the result into the shift register and result_q, then go to READY.
REQ-016 READY: miso SHALL present result bit DATA_W-1 and the state SHALL hold while nss=1.
REQ-017 READY, edge with nss=0: SHALL go to SEND with the shift register advanced one bit (miso = bit DATA_W-2), and the sent-bit counter set to 1.
REQ-018 SEND: each edge with nss=0 SHALL advance miso one bit, MSB first; on the edge where the sent count reaches DATA_W, the block SHALL go to IDLE and miso SHALL return to 0.
REQ-019 SEND, edge with nss=1 before DATA_W bits are sent: SHALL pulse frame_err and go to IDLE.
REQ-020 The response SHALL occupy exactly DATA_W consecutive nss-low cycles: miso holds bit DATA_W-1 in the first such cycle and bit 0 in the last.
REQ-021 miso SHALL be registered; it is never driven combinationally from mosi.
REQ-022 New frames SHALL be ignored while in CALC or READY; nss activity in READY is treated only as the response select.

Reset
REQ-023 While reset=1, at any edge: state SHALL be IDLE, and miso, frame_err, busy, counters, frame register and result_q SHALL all be 0.
REQ-024 reset SHALL take priority over every nss/mosi event, including mid-RECV or mid-SEND; no partial result SHALL survive.

Verification
REQ-025 ADD: frame 00, A=0x00000005, B=0x00000007, 66 bits, then nss high -> after 1 CALC cycle result_q=0x0000000C; 32-cycle read returns 0x0000000C MSB first.
REQ-026 SUB and wrap: 01, A=3, B=5 -> 0xFFFFFFFE; ADD A=0xFFFFFFFF, B=1 -> 0x00000000.
REQ-027 Logic ops: 10, A=0xF0F0F0F0, B=0xFF00FF00 -> 0xF000F000; 11 with the same operands -> 0x0FF00FF0.
REQ-028 Short frame: 40 bits then nss high -> frame_err one cycle, state IDLE, result_q unchanged; the next valid frame computes correctly.
REQ-029 Aborted read: nss high after 10 response bits -> frame_err pulse, IDLE; a 67-bit frame -> frame_err, no result.
REQ-030 Reset asserted at RECV bit 30 -> all outputs 0 on the next edge; a full frame after reset deasserts yields the correct result.
